// File: rtl/pong_referee.sv
// Pong game referee: sequences the ball FSM (serve / play / scored / game over),
// detects paddle, wall and goal events on each ball step, keeps score and
// drives the ball's bounce and speed inputs. Every output is registered.
// Optional build macro SERVE_DELAY_EN: once the ball re-centres, hold the
// serve for SERVE_CYCLES further clocks before entering play.
module pong_referee #(
    parameter int unsigned SCREEN_X         = 640,
    parameter int unsigned SCREEN_Y         = 480,
    parameter int unsigned PADDLE_L_X       = 16,
    parameter int unsigned PADDLE_R_X       = 616,
    parameter int unsigned PADDLE_W         = 8,
    parameter int unsigned PADDLE_H         = 64,
    parameter int unsigned SPEED_INIT       = 6,
    parameter int unsigned SPEED_MIN        = 1,
    parameter int unsigned HITS_PER_SPEEDUP = 3,
    parameter int unsigned WIN_SCORE        = 9,
    parameter int unsigned SERVE_CYCLES     = 1000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [9:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    input  logic [7:0] i_ball_w,
    input  logic [7:0] i_ball_h,
    input  logic [9:0] i_paddle_l_y,
    input  logic [9:0] i_paddle_r_y,
    output logic [1:0] o_bounce,
    output logic [2:0] o_speed,
    output logic [3:0] o_score_l,
    output logic [3:0] o_score_r,
    output logic [1:0] o_winner,
    output logic       o_playing
);

    typedef enum logic [2:0] {StIdle, StServe, StPlay, StScored, StGameOver} state_e;

    localparam logic [10:0] SCR_X    = 11'(SCREEN_X);
    localparam logic [10:0] SCR_Y    = 11'(SCREEN_Y);
    localparam logic [9:0]  CTR_X    = 10'(SCREEN_X / 2);
    localparam logic [9:0]  CTR_Y    = 10'(SCREEN_Y / 2);
    localparam logic [10:0] L_HIT_X  = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] R_HIT_X  = 11'(PADDLE_R_X);
    localparam logic [10:0] PAD_H    = 11'(PADDLE_H);
    localparam logic [2:0]  SPD_INIT = 3'(SPEED_INIT);
    localparam logic [2:0]  SPD_MIN  = 3'(SPEED_MIN);
    localparam logic [7:0]  HITS_MAX = 8'(HITS_PER_SPEEDUP);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

    state_e     r_state, w_state_next;
    logic [9:0] r_prev_x, r_prev_y;
    logic       r_dir_x, r_start_q, r_scorer_l, w_scorer_l_next;
    logic [1:0] r_bounce, w_bounce_next, r_winner, w_winner_next;
    logic [2:0] r_speed, w_speed_next;
    logic [7:0] r_hits, w_hits_next;
    logic [3:0] r_score_l, w_score_l_next, r_score_r, w_score_r_next;
    logic       r_playing;

    // 11-bit edge sums so a ball near the border never wraps
    logic [10:0] w_ball_r, w_ball_b;
    logic        w_step, w_dir_x, w_centred, w_l_ovl, w_r_ovl, w_hit, w_wall;

    assign w_ball_r  = {1'b0, i_ball_x} + {3'b0, i_ball_w};
    assign w_ball_b  = {1'b0, i_ball_y} + {3'b0, i_ball_h};
    assign w_step    = (i_ball_x != r_prev_x) || (i_ball_y != r_prev_y);
    // Direction from this step's own x delta; a pure-y step keeps the last one
    assign w_dir_x   = (i_ball_x != r_prev_x) ? (i_ball_x > r_prev_x) : r_dir_x;
    assign w_centred = (i_ball_x == CTR_X) && (i_ball_y == CTR_Y);
    assign w_l_ovl   = ({1'b0, i_ball_y} < ({1'b0, i_paddle_l_y} + PAD_H)) &&
                       (w_ball_b > {1'b0, i_paddle_l_y});
    assign w_r_ovl   = ({1'b0, i_ball_y} < ({1'b0, i_paddle_r_y} + PAD_H)) &&
                       (w_ball_b > {1'b0, i_paddle_r_y});
    assign w_hit     = (!w_dir_x && ({1'b0, i_ball_x} == L_HIT_X) && w_l_ovl) ||
                       ( w_dir_x && (w_ball_r == R_HIT_X) && w_r_ovl);
    assign w_wall    = (i_ball_y == 10'd0) || (w_ball_b >= SCR_Y);

`ifdef SERVE_DELAY_EN
    logic [15:0] r_serve_cnt, w_serve_cnt_next;
    logic        r_centred, w_centred_next;
`endif

    // Next-state and next-output logic for the game flow
    always_comb begin
        w_state_next    = r_state;
        w_bounce_next   = r_bounce;
        w_speed_next    = r_speed;
        w_hits_next     = r_hits;
        w_score_l_next  = r_score_l;
        w_score_r_next  = r_score_r;
        w_winner_next   = r_winner;
        w_scorer_l_next = r_scorer_l;
`ifdef SERVE_DELAY_EN
        w_serve_cnt_next = r_serve_cnt;
        w_centred_next   = r_centred;
`endif
        unique case (r_state)
            StIdle: begin
                w_bounce_next = 2'b11;
                if (i_start) w_state_next = StServe;
            end
            StServe: begin
                w_bounce_next = 2'b11;
`ifdef SERVE_DELAY_EN
                if (!r_centred) begin
                    if (w_centred) begin
                        w_centred_next   = 1'b1;
                        w_serve_cnt_next = 16'd0;
                    end
                end else if (r_serve_cnt == 16'(SERVE_CYCLES - 1)) begin
                    w_speed_next  = SPD_INIT;
                    w_hits_next   = 8'd0;
                    w_bounce_next = 2'b00;
                    w_state_next  = StPlay;
                end else begin
                    w_serve_cnt_next = r_serve_cnt + 16'd1;
                end
`else
                if (w_centred) begin
                    w_speed_next  = SPD_INIT;
                    w_hits_next   = 8'd0;
                    w_bounce_next = 2'b00;
                    w_state_next  = StPlay;
                end
`endif
            end
            StPlay: begin
                if (w_step) begin
                    if (i_ball_x == 10'd0) begin
                        w_scorer_l_next = 1'b0;
                        w_bounce_next   = 2'b11;
                        w_state_next    = StScored;
                    end else if (w_ball_r >= SCR_X) begin
                        w_scorer_l_next = 1'b1;
                        w_bounce_next   = 2'b11;
                        w_state_next    = StScored;
                    end else if (w_hit) begin
                        w_bounce_next = 2'b01;
                        if (r_hits + 8'd1 >= HITS_MAX) begin
                            w_hits_next = 8'd0;
                            if (r_speed > SPD_MIN) w_speed_next = r_speed - 3'd1;
                        end else begin
                            w_hits_next = r_hits + 8'd1;
                        end
                    end else if (w_wall) begin
                        w_bounce_next = 2'b10;
                    end else begin
                        w_bounce_next = 2'b00;
                    end
                end
            end
            StScored: begin
                w_bounce_next = 2'b11;
                w_state_next  = StServe;
                if (r_scorer_l) begin
                    if (r_score_l < WIN) w_score_l_next = r_score_l + 4'd1;
                    if (r_score_l + 4'd1 >= WIN) begin
                        w_winner_next = 2'b01;
                        w_state_next  = StGameOver;
                    end
                end else begin
                    if (r_score_r < WIN) w_score_r_next = r_score_r + 4'd1;
                    if (r_score_r + 4'd1 >= WIN) begin
                        w_winner_next = 2'b10;
                        w_state_next  = StGameOver;
                    end
                end
            end
            StGameOver: begin
                w_bounce_next = 2'b11;
                // Only a fresh press restarts; a start held from last game is ignored
                if (i_start && !r_start_q) begin
                    w_score_l_next = 4'd0;
                    w_score_r_next = 4'd0;
                    w_winner_next  = 2'b00;
                    w_state_next   = StServe;
                end
            end
            default: w_state_next = StIdle;
        endcase
`ifdef SERVE_DELAY_EN
        if ((w_state_next == StServe) && (r_state != StServe)) begin
            w_serve_cnt_next = 16'd0;
            w_centred_next   = 1'b0;
        end
`endif
    end

    // State, position history and registered outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_prev_x   <= 10'd0;
            r_prev_y   <= 10'd0;
            r_dir_x    <= 1'b0;
            r_start_q  <= 1'b0;
            r_scorer_l <= 1'b0;
            r_bounce   <= 2'b11;
            r_speed    <= SPD_INIT;
            r_hits     <= 8'd0;
            r_score_l  <= 4'd0;
            r_score_r  <= 4'd0;
            r_winner   <= 2'b00;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prev_x   <= i_ball_x;
            r_prev_y   <= i_ball_y;
            r_dir_x    <= w_dir_x;
            r_start_q  <= i_start;
            r_scorer_l <= w_scorer_l_next;
            r_bounce   <= w_bounce_next;
            r_speed    <= w_speed_next;
            r_hits     <= w_hits_next;
            r_score_l  <= w_score_l_next;
            r_score_r  <= w_score_r_next;
            r_winner   <= w_winner_next;
            r_playing  <= (w_state_next == StPlay);
        end
    end

`ifdef SERVE_DELAY_EN
    // Serve-delay counter, cleared whenever SERVE is entered
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_serve_cnt <= 16'd0;
            r_centred   <= 1'b0;
        end else begin
            r_serve_cnt <= w_serve_cnt_next;
            r_centred   <= w_centred_next;
        end
    end
`endif

    assign o_bounce  = r_bounce;
    assign o_speed   = r_speed;
    assign o_score_l = r_score_l;
    assign o_score_r = r_score_r;
    assign o_winner  = r_winner;
    assign o_playing = r_playing;

endmodule

// File: doc/pong_referee.md
Name: pong_referee

Overview:
- Game-level controller that sequences the ball FSM.
- Watches ball position/size and both paddle positions, and drives the ball's `bounce[1:0]` and `speed[2:0]` inputs.
- Keeps score and runs the serve / play / game-over flow.
- Sits between the paddle blocks, the ball block and the score display in the Pong top level.

Parameters:
- SCREEN_X, 640, visible width in pixels
- SCREEN_Y, 480, visible height in pixels
- PADDLE_L_X, 16, left paddle left edge x
- PADDLE_R_X, 616, right paddle left edge x
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- SPEED_INIT, 6, ball step divider after serve (larger = slower)
- SPEED_MIN, 1, fastest allowed divider
- HITS_PER_SPEEDUP, 3, paddle hits per divider decrement
- WIN_SCORE, 9, points that end the game
- SERVE_CYCLES, 1000, serve pause in clocks (SERVE_DELAY_EN only)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; begins a game from IDLE/GAME_OVER
- ball_x  in  10  ball pos_x
- ball_y  in  10  ball pos_y
- ball_w  in  8  ball size_x
- ball_h  in  8  ball size_y
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- bounce  out  2  to ball: 00 none, 01 paddle, 10 wall, 11 re-serve
- speed  out  3  to ball divider
- score_l  out  4  left player score
- score_r  out  4  right player score
- winner  out  2  00 none, 01 left, 10 right
- playing  out  1  high in PLAY

Behaviour:
Reset (reset=0, async) and its values:
- State IDLE; bounce=11; speed=SPEED_INIT; score_l=score_r=0; winner=00; playing=0; hit counter=0.
- Position history registers are cleared to 0.
- Every output is registered.

Step detection:
- A step occurs when (ball_x, ball_y) differs from the copy registered the previous clock.
- dir_x is latched from the sign of the x delta on each step: 1 = moving right.

Evaluation:
- Runs only in PLAY, on a step cycle. The result is registered, so bounce changes the clock after the step.
- bounce then holds until the next step.
- Width rule: right/bottom edges are computed as 11-bit sums (ball_x+ball_w, ball_y+ball_h), so there is no wrap.

Priority, highest first:
1. Score:
   - ball_x==0 → right scores.
   - ball_x+ball_w >= SCREEN_X → left scores.
   - Either goes to SCORED.
2. Paddle → bounce=01, hit counter +1. Either of:
   - dir_x=0 and ball_x==PADDLE_L_X+PADDLE_W and y-overlap with paddle_l_y..paddle_l_y+PADDLE_H-1;
   - dir_x=1 and ball_x+ball_w==PADDLE_R_X and y-overlap with the right paddle.
3. Wall: ball_y==0 or ball_y+ball_h >= SCREEN_Y → bounce=10.
4. Otherwise bounce=00.
- Simultaneous paddle and wall (corner): the paddle wins; the wall is handled on the next step.

Speed-up:
- When the hit counter reaches HITS_PER_SPEEDUP, it clears and speed decrements, saturating at SPEED_MIN.

States:
- IDLE: bounce=11.
  - start=1 → SERVE.
- SERVE: bounce=11.
  - Waits until ball_x==SCREEN_X/2 and ball_y==SCREEN_Y/2, i.e. the ball has re-centred.
  - Then speed=SPEED_INIT and hit counter=0; bounce=00 → PLAY.
- PLAY: playing=1; evaluation as above.
- SCORED: the scoring side's score increments exactly once (on entry).
  - If the new score == WIN_SCORE: winner set → GAME_OVER.
  - Otherwise → SERVE.
- GAME_OVER: bounce=11; scores and winner frozen.
  - A rising edge of start clears scores and winner → SERVE.
  - start held high from the previous game does not restart.

Scores:
- 4-bit, never exceed WIN_SCORE, never wrap.
- reset low mid-game returns everything to the reset values immediately.

Optional Feature:
- Macro: SERVE_DELAY_EN
- Defined:
  - After the ball re-centres in SERVE, bounce stays 11 for a further SERVE_CYCLES clocks before PLAY.
  - The counter is 16-bit and cleared on SERVE entry.
- Undefined: PLAY is entered the clock after the re-centre is detected, with no counter logic.

Test Plan:
- Reset, start=1 with the ball at (320,240) → SERVE then PLAY within 2 clocks; bounce=00, speed=6, playing=1.
- Ball steps to y=0 with x=300 → bounce=10 the clock after the step, held until the next step, then 00.
- dir_x=0, ball steps to x=24, paddle_l_y=200, ball_y=230 → bounce=01. Three such hits → speed 6→5; repeated hits saturate at 1.
- Ball steps to x=0 → score_r 0→1, bounce=11 until the ball reports (320,240), then PLAY. With SERVE_DELAY_EN, PLAY is entered exactly 1000 clocks after the centre is seen.
- score_l=8 and the ball reaches x+w=640 → score_l=9, winner=01, GAME_OVER. start held high does not restart; a new start rising edge clears the scores.
- Paddle and wall on the same step (corner) → bounce=01, not 10. Asserting reset low mid-PLAY → all outputs return to reset values without waiting for a clock.
